pipe_skid_buf: RTL and testbench

//  Receiving end of an inter-stage pipeline link. Registers a valid/ready stream between two pipeline stages.

---
 rtl/nanosoc_pipe_pkg.sv | 13 +
 rtl/pipe_skid_buf.sv | 104 ++++++++++
 tb/tb_pipe_skid_buf.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/nanosoc_pipe_pkg.sv
// Shared definitions for nanosoc pipeline link stages.
// Holds the skid-buffer occupancy state type and the default payload width.
package nanosoc_pipe_pkg;

    localparam int unsigned DefaultDataW = 32;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer on the receiving end of a valid/ready pipeline link.
// ready_o is decoded from the state register only, so no combinational path from ready_i.
module pipe_skid_buf
    import nanosoc_pipe_pkg::*;
#(
    parameter int unsigned         DATA_W  = DefaultDataW,
    parameter logic [DATA_W-1:0]   RST_VAL = DATA_W'(32'hDEADBEEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] d_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] q_o,
    output logic [1:0]        count_o
);

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              push, pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            main_q  <= RST_VAL;
            skid_q  <= RST_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Unused encoding reports neither valid nor ready, so nothing is accepted and then lost.
    always_comb begin
        valid_o = 1'b0;
        ready_o = 1'b0;
        count_o = 2'd0;
        case (state_q)
            StEmpty: begin
                ready_o = 1'b1;
            end
            StOne: begin
                valid_o = 1'b1;
                ready_o = 1'b1;
                count_o = 2'd1;
            end
            StTwo: begin
                valid_o = 1'b1;
                count_o = 2'd2;
            end
            default: begin
                valid_o = 1'b0;
            end
        endcase
    end

    assign push = valid_i & ready_o;
    assign pop  = valid_o & ready_i;
    assign q_o  = main_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            StEmpty: begin
                if (push) begin
                    state_d = StOne;
                    main_d  = d_i;
                end
            end
            StOne: begin
                if (push && pop) begin
                    main_d = d_i;
                end else if (push) begin
                    state_d = StTwo;
                    skid_d  = d_i;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (pop) begin
                    state_d = StOne;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
        // Squash wins over any handshake on the same edge.
        if (flush_i) begin
            state_d = StEmpty;
            main_d  = RST_VAL;
        end
    end

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Self-checking bench for pipe_skid_buf: directed table, streaming, flush and async-reset
// sequences, then random traffic against a queue-based reference model.
module tb_pipe_skid_buf;

    localparam logic [31:0] RstVal = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] d_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] q_o;
    logic [1:0]  count_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] mq[$];
    logic [31:0] mhold;

    always #5 clk = ~clk;

    pipe_skid_buf #(
        .DATA_W (32),
        .RST_VAL(RstVal)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .flush_i(flush_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .d_i    (d_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .q_o    (q_o),
        .count_o(count_o)
    );

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        r;
        logic        f;
        logic        ev;
        logic        er;
        logic [1:0]  ec;
        logic [31:0] eq;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_q();
        return (mq.size() > 0) ? mq[0] : mhold;
    endfunction

    task automatic model_reset();
        mq.delete();
        mhold = RstVal;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " valid_o"}, 32'(valid_o), 32'(mq.size() > 0));
        chk({tag, " ready_o"}, 32'(ready_o), 32'(mq.size() < 2));
        chk({tag, " count_o"}, 32'(count_o), 32'(mq.size()));
        chk({tag, " q_o"}, q_o, model_q());
    endtask

    // Called at a negedge: drive inputs, take one rising edge, compare at the next negedge.
    task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f,
                        input string tag);
        bit push, pop;
        valid_i = v;
        d_i     = d;
        ready_i = r;
        flush_i = f;
        push = v && (mq.size() < 2);
        pop  = (mq.size() > 0) && r;
        @(posedge clk);
        if (f) begin
            mq.delete();
            mhold = RstVal;
        end else begin
            if (pop) mhold = mq.pop_front();
            if (push) mq.push_back(d);
        end
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic add(input logic v, input logic [31:0] d, input logic r, input logic f,
                       input logic ev, input logic er, input logic [1:0] ec,
                       input logic [31:0] eq);
        vec_t t;
        t.v = v; t.d = d; t.r = r; t.f = f;
        t.ev = ev; t.er = er; t.ec = ec; t.eq = eq;
        tbl.push_back(t);
    endtask

    initial begin
        rst     = 1'b1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        d_i     = '0;
        model_reset();

        // single transfer
        add(1, 32'h42, 1, 0, 1, 1, 2'd1, 32'h42);
        add(0, 32'h0,  1, 0, 0, 1, 2'd0, 32'h42);
        // back-pressure
        add(1, 32'h1,  0, 0, 1, 1, 2'd1, 32'h1);
        add(1, 32'h2,  0, 0, 1, 0, 2'd2, 32'h1);
        add(0, 32'h0,  1, 0, 1, 1, 2'd1, 32'h2);
        add(0, 32'h0,  1, 0, 0, 1, 2'd0, 32'h2);
        // flush priority from full
        add(1, 32'hA,  0, 0, 1, 1, 2'd1, 32'hA);
        add(1, 32'hB,  0, 0, 1, 0, 2'd2, 32'hA);
        add(1, 32'h99, 0, 1, 0, 1, 2'd0, RstVal);
        add(0, 32'h0,  1, 0, 0, 1, 2'd0, RstVal);
        // flush with simultaneous push and pop from one entry
        add(1, 32'h5,  1, 0, 1, 1, 2'd1, 32'h5);
        add(1, 32'h6,  1, 1, 0, 1, 2'd0, RstVal);
        // push and pop together, then hold under back-pressure
        add(1, 32'h7,  1, 0, 1, 1, 2'd1, 32'h7);
        add(1, 32'h8,  1, 0, 1, 1, 2'd1, 32'h8);
        add(0, 32'h0,  0, 0, 1, 1, 2'd1, 32'h8);
        add(0, 32'h0,  0, 0, 1, 1, 2'd1, 32'h8);
        add(0, 32'h0,  1, 0, 0, 1, 2'd0, 32'h8);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset valid_o", 32'(valid_o), 32'd0);
        chk("reset ready_o", 32'(ready_o), 32'd1);
        chk("reset count_o", 32'(count_o), 32'd0);
        chk("reset q_o", q_o, RstVal);

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].f, $sformatf("vec%0d model", i));
            chk($sformatf("vec%0d valid_o", i), 32'(valid_o), 32'(tbl[i].ev));
            chk($sformatf("vec%0d ready_o", i), 32'(ready_o), 32'(tbl[i].er));
            chk($sformatf("vec%0d count_o", i), 32'(count_o), 32'(tbl[i].ec));
            chk($sformatf("vec%0d q_o", i), q_o, tbl[i].eq);
        end

        // streaming: one word per cycle, occupancy stays at one
        for (int i = 0; i < 16; i++) begin
            step(1, 32'(i), 1, 0, "stream model");
            chk("stream q_o", q_o, 32'(i));
            chk("stream count_o", 32'(count_o), 32'd1);
        end
        step(0, 32'h0, 1, 0, "stream drain");

        // async reset while full, asserted between edges
        step(1, 32'h11, 0, 0, "areset fill1");
        step(1, 32'h22, 0, 0, "areset fill2");
        chk("areset pre count_o", 32'(count_o), 32'd2);
        valid_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("areset valid_o", 32'(valid_o), 32'd0);
        chk("areset ready_o", 32'(ready_o), 32'd1);
        chk("areset count_o", 32'(count_o), 32'd0);
        chk("areset q_o", q_o, RstVal);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_model("areset release");

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 15) == 0), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
